bu_writeback: RTL
=================

BU_WRITEBACK -- requirements
Module: bu_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 13; coefficient ports are DATA_WIDTH-1 bits wide.
REQ-002 Parameter ADDR_WIDTH, default 5; this is the BRAM bank address width.
REQ-003 Parameter BU_LATENCY, default 3, legal range 1..8; it is the BU input-to-output delay in cycles.
REQ-004 Parameter WR_PER_STAGE, default 16; it is the number of write beats per NTT stage.
REQ-005 clk_i  in  1  single clock; all logic rises on its positive edge.
REQ-006 rst_i  in  1  asynchronous, active-low reset.
REQ-007 in_valid_i  in  1  high in the cycle BU inputs are presented (same cycle as start_BU_choose).
REQ-008 len_i  in  8  stage length for that beat; legal values are 128, 64, 32, 16, 8, 4, 2.
REQ-009 is_ntt_i  in  1  beat mode: 1 selects NTT results, 0 selects iNTT results.
REQ-010 rd_addr_a_i, rd_addr_b_i  in  ADDR_WIDTH each  port-A and port-B read addresses of that beat.
REQ-011 A_NTT0..7, B_NTT0..7, A_iNTT0..7, B_iNTT0..7  in  DATA_WIDTH-1 each  BU results.
REQ-012 wr_data_a0..7, wr_data_b0..7  out  DATA_WIDTH-1 each  bank n port-A / port-B write data.
REQ-013 wr_addr_a_o, wr_addr_b_o  out  ADDR_WIDTH each  write addresses.
REQ-014 wr_en_o  out  1  write strobe, common to all 16 ports.
REQ-015 busy_o  out  1  high while any beat is in flight.
REQ-016 stage_done_o  out  1  single-cycle pulse per completed stage.
REQ-017 err_o  out  1  sticky illegal-len flag.

Function
REQ-018 A delay line of depth BU_LATENCY SHALL carry {valid, len, is_ntt, addr_a, addr_b} for each beat.
REQ-019 Outputs SHALL be registered, so wr_en_o rises exactly BU_LATENCY+1 cycles after the in_valid_i of the same beat.
REQ-020 Result selection SHALL use the delayed is_ntt of the beat (A_NTTk/B_NTTk when 1, A_iNTTk/B_iNTTk when 0), never the live is_ntt_i.
REQ-021 Writeback SHALL be in place, with wr_addr_a_o/wr_addr_b_o equal to the beat's delayed rd_addr_a_i/rd_addr_b_i; notation Xa/Xb below means bank X port A / port B, and k.A/k.B means BU k A/B result.
REQ-022 For len 128: bank 2j port A SHALL take j.A, bank 2j+1 port A SHALL take j.B, bank 2j port B SHALL take (j+4).A, and bank 2j+1 port B SHALL take (j+4).B, for j=0..3.
REQ-023 For len 64: 0a/1a take 0.A/0.B, 2a/3a take 1, 4a/5a take 4, 6a/7a take 5, 0b/1b take 2, 2b/3b take 3, 4b/5b take 6, and 6b/7b take 7 (each pair as A/B).
REQ-024 For len 32: 0a/1a take 0, 2a/3a take 2, 4a/5a take 4, 6a/7a take 6, 0b/1b take 1, 2b/3b take 3, 4b/5b take 5, and 6b/7b take 7.
REQ-025 For len 16/8/4/2: 0a/0b take 0, 1a/1b take 1, 2a/3a take 2, 2b/3b take 3, 4a/5a take 4, 4b/5b take 5, 6a/7a take 6, and 6b/7b take 7.
REQ-026 When wr_en_o=0, all wr_data and wr_addr outputs SHALL be 0.
REQ-027 A beat with an illegal delayed len SHALL produce no write, SHALL set err_o, and SHALL not be counted.
REQ-028 A counter SHALL count write beats from 0 to WR_PER_STAGE-1 and wrap to 0.
REQ-029 stage_done_o SHALL pulse in the cycle after the WR_PER_STAGE-th write.
REQ-030 FSM state IDLE SHALL move to FILL on in_valid_i.
REQ-031 FILL SHALL move to WRITE on the first delayed valid.
REQ-032 WRITE SHALL move to DONE on the final beat of a stage.
REQ-033 DONE SHALL last one cycle, asserting stage_done_o, and SHALL then go to FILL if any beat is in flight and to IDLE otherwise.
REQ-034 Back-to-back stages SHALL be supported: in_valid_i may stay high across a stage boundary with no bubble, and len/is_ntt may change per beat.
REQ-035 Gaps in in_valid_i SHALL be permitted; the counter holds during gaps.
REQ-036 busy_o SHALL equal the OR of all delay-line valid bits, the output valid register, and (state != IDLE).

Reset
REQ-037 While rst_i=0: delay line cleared, counter=0, FSM=IDLE, and all outputs including err_o =0.
REQ-038 A reset asserted mid-stage SHALL discard all in-flight beats, with no write strobe after reset is released.

Structure
REQ-039 Package ntt_pkg SHALL hold the legal len constants (LEN_128..LEN_2), the FSM state enum, and the write-port-to-BU mapping as a function of len.
REQ-040 Sub-module bu_wb_delay (a parameterised shift register with valid) SHALL implement the delay line.

Verification
REQ-041 len 128, NTT, 16 consecutive beats with addr_a=i, addr_b=i+16 -> wr_en_o on cycles 4..19 after the first beat, data per REQ-022, one stage_done_o on cycle 20.
REQ-042 len 64, then 32, then 16 in three back-to-back stages -> 48 writes with no gaps, correct bank routing each, and three stage_done_o pulses.
REQ-043 iNTT beat with A_NTT0=0x111, A_iNTT0=0x222, len 2 -> wr_data_a0=0x222 written to bank 0 port A.
REQ-044 len_i=8'd100 on one beat -> no wr_en_o for that beat, err_o=1 and held, counter unchanged.
REQ-045 Reset pulse two cycles after 5 beats -> no wr_en_o afterwards, busy_o=0, counter=0.
REQ-046 in_valid_i alternating 1/0 for 32 cycles -> 16 writes spaced two cycles apart, one stage_done_o.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, FSM states and bank routing for the NTT writeback path.
// wb_map() returns the BU result index {bu, sel_b} feeding one bank write port.
package ntt_pkg;

    localparam logic [7:0] LEN_128 = 8'd128;
    localparam logic [7:0] LEN_64  = 8'd64;
    localparam logic [7:0] LEN_32  = 8'd32;
    localparam logic [7:0] LEN_16  = 8'd16;
    localparam logic [7:0] LEN_8   = 8'd8;
    localparam logic [7:0] LEN_4   = 8'd4;
    localparam logic [7:0] LEN_2   = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } wb_state_t;

    function automatic logic len_legal(input logic [7:0] len);
        return len inside {LEN_128, LEN_64, LEN_32, LEN_16,
                           LEN_8, LEN_4, LEN_2};
    endfunction

    // Result index = {bu[2:0], sel_b}; sel_b picks the B output of that BU.
    // Banks pair up as (2p, 2p+1); the odd bank of a pair usually takes B.
    function automatic logic [3:0] wb_map(
        input logic [7:0] len,
        input logic [2:0] bank,
        input logic       port_b
    );
        logic [1:0] p;
        logic [2:0] bu;
        logic       sel;
        p   = bank[2:1];
        bu  = '0;
        sel = bank[0];
        unique case (1'b1)
            len == LEN_128: bu = {port_b, p};
            len == LEN_64:  bu = {p[1], port_b, p[0]};
            len == LEN_32:  bu = {p, port_b};
            default: begin
                // short stages: banks 0/1 each hold one whole BU (A on
                // port A, B on port B); the upper pairs interleave.
                if (p == 2'd0) begin
                    bu  = {2'b00, bank[0]};
                    sel = port_b;
                end else begin
                    bu  = {p, port_b};
                end
            end
        endcase
        return {bu, sel};
    endfunction

endpackage

// File: rtl/bu_wb_delay.sv
// Shift register with valid that matches the butterfly-unit latency.
// Ports: clk_i, rst_i (async low), in_valid_i/in_data_i, out_*, vld_o taps.
module bu_wb_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [W-1:0]     in_data_i,
    output logic             out_valid_o,
    output logic [W-1:0]     out_data_o,
    output logic [DEPTH-1:0] vld_o
);

    logic [DEPTH-1:0]        v_q;
    logic [DEPTH-1:0][W-1:0] d_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q[0] <= in_valid_i;
            d_q[0] <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign out_valid_o = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];
    assign vld_o       = v_q;

endmodule

// File: rtl/bu_writeback.sv
// In-place writeback of 8 butterfly results (A/B) into 8 dual-port banks.
// Ports: beat info in, BU results in, 16 write-data/2 addr/wr_en out, status.
module bu_writeback
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH   = 13,
    parameter int ADDR_WIDTH   = 5,
    parameter int BU_LATENCY   = 3,
    parameter int WR_PER_STAGE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            len_i,
    input  logic                  is_ntt_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
    input  logic [DATA_WIDTH-2:0] A_NTT0,
    input  logic [DATA_WIDTH-2:0] A_NTT1,
    input  logic [DATA_WIDTH-2:0] A_NTT2,
    input  logic [DATA_WIDTH-2:0] A_NTT3,
    input  logic [DATA_WIDTH-2:0] A_NTT4,
    input  logic [DATA_WIDTH-2:0] A_NTT5,
    input  logic [DATA_WIDTH-2:0] A_NTT6,
    input  logic [DATA_WIDTH-2:0] A_NTT7,
    input  logic [DATA_WIDTH-2:0] B_NTT0,
    input  logic [DATA_WIDTH-2:0] B_NTT1,
    input  logic [DATA_WIDTH-2:0] B_NTT2,
    input  logic [DATA_WIDTH-2:0] B_NTT3,
    input  logic [DATA_WIDTH-2:0] B_NTT4,
    input  logic [DATA_WIDTH-2:0] B_NTT5,
    input  logic [DATA_WIDTH-2:0] B_NTT6,
    input  logic [DATA_WIDTH-2:0] B_NTT7,
    input  logic [DATA_WIDTH-2:0] A_iNTT0,
    input  logic [DATA_WIDTH-2:0] A_iNTT1,
    input  logic [DATA_WIDTH-2:0] A_iNTT2,
    input  logic [DATA_WIDTH-2:0] A_iNTT3,
    input  logic [DATA_WIDTH-2:0] A_iNTT4,
    input  logic [DATA_WIDTH-2:0] A_iNTT5,
    input  logic [DATA_WIDTH-2:0] A_iNTT6,
    input  logic [DATA_WIDTH-2:0] A_iNTT7,
    input  logic [DATA_WIDTH-2:0] B_iNTT0,
    input  logic [DATA_WIDTH-2:0] B_iNTT1,
    input  logic [DATA_WIDTH-2:0] B_iNTT2,
    input  logic [DATA_WIDTH-2:0] B_iNTT3,
    input  logic [DATA_WIDTH-2:0] B_iNTT4,
    input  logic [DATA_WIDTH-2:0] B_iNTT5,
    input  logic [DATA_WIDTH-2:0] B_iNTT6,
    input  logic [DATA_WIDTH-2:0] B_iNTT7,
    output logic [DATA_WIDTH-2:0] wr_data_a0,
    output logic [DATA_WIDTH-2:0] wr_data_a1,
    output logic [DATA_WIDTH-2:0] wr_data_a2,
    output logic [DATA_WIDTH-2:0] wr_data_a3,
    output logic [DATA_WIDTH-2:0] wr_data_a4,
    output logic [DATA_WIDTH-2:0] wr_data_a5,
    output logic [DATA_WIDTH-2:0] wr_data_a6,
    output logic [DATA_WIDTH-2:0] wr_data_a7,
    output logic [DATA_WIDTH-2:0] wr_data_b0,
    output logic [DATA_WIDTH-2:0] wr_data_b1,
    output logic [DATA_WIDTH-2:0] wr_data_b2,
    output logic [DATA_WIDTH-2:0] wr_data_b3,
    output logic [DATA_WIDTH-2:0] wr_data_b4,
    output logic [DATA_WIDTH-2:0] wr_data_b5,
    output logic [DATA_WIDTH-2:0] wr_data_b6,
    output logic [DATA_WIDTH-2:0] wr_data_b7,
    output logic [ADDR_WIDTH-1:0] wr_addr_a_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_b_o,
    output logic                  wr_en_o,
    output logic                  busy_o,
    output logic                  stage_done_o,
    output logic                  err_o
);

    localparam int CW    = DATA_WIDTH - 1;
    localparam int PW    = 8 + 1 + 2 * ADDR_WIDTH;
    localparam int CNT_W = (WR_PER_STAGE > 1) ? $clog2(WR_PER_STAGE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_PER_STAGE - 1);

    logic [CW-1:0] res_ntt  [16];
    logic [CW-1:0] res_intt [16];

    assign res_ntt[0]  = A_NTT0;
    assign res_ntt[1]  = B_NTT0;
    assign res_ntt[2]  = A_NTT1;
    assign res_ntt[3]  = B_NTT1;
    assign res_ntt[4]  = A_NTT2;
    assign res_ntt[5]  = B_NTT2;
    assign res_ntt[6]  = A_NTT3;
    assign res_ntt[7]  = B_NTT3;
    assign res_ntt[8]  = A_NTT4;
    assign res_ntt[9]  = B_NTT4;
    assign res_ntt[10] = A_NTT5;
    assign res_ntt[11] = B_NTT5;
    assign res_ntt[12] = A_NTT6;
    assign res_ntt[13] = B_NTT6;
    assign res_ntt[14] = A_NTT7;
    assign res_ntt[15] = B_NTT7;

    assign res_intt[0]  = A_iNTT0;
    assign res_intt[1]  = B_iNTT0;
    assign res_intt[2]  = A_iNTT1;
    assign res_intt[3]  = B_iNTT1;
    assign res_intt[4]  = A_iNTT2;
    assign res_intt[5]  = B_iNTT2;
    assign res_intt[6]  = A_iNTT3;
    assign res_intt[7]  = B_iNTT3;
    assign res_intt[8]  = A_iNTT4;
    assign res_intt[9]  = B_iNTT4;
    assign res_intt[10] = A_iNTT5;
    assign res_intt[11] = B_iNTT5;
    assign res_intt[12] = A_iNTT6;
    assign res_intt[13] = B_iNTT6;
    assign res_intt[14] = A_iNTT7;
    assign res_intt[15] = B_iNTT7;

    // Beat descriptor travels alongside the BU so routing uses its own mode.
    logic [PW-1:0]         dly_in;
    logic [PW-1:0]         dly_out;
    logic                  d_valid;
    logic [BU_LATENCY-1:0] d_vld;
    logic [7:0]            d_len;
    logic                  d_ntt;
    logic [ADDR_WIDTH-1:0] d_ra;
    logic [ADDR_WIDTH-1:0] d_rb;

    assign dly_in = {len_i, is_ntt_i, rd_addr_a_i, rd_addr_b_i};

    bu_wb_delay #(
        .W     (PW),
        .DEPTH (BU_LATENCY)
    ) u_delay (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (dly_in),
        .out_valid_o (d_valid),
        .out_data_o  (dly_out),
        .vld_o       (d_vld)
    );

    assign {d_len, d_ntt, d_ra, d_rb} = dly_out;

    logic d_legal;
    logic wr_go;

    assign d_legal = len_legal(d_len);
    assign wr_go   = d_valid & d_legal;

    logic [CW-1:0] nxt_a [8];
    logic [CW-1:0] nxt_b [8];

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            nxt_a[n] = d_ntt ? res_ntt[wb_map(d_len, 3'(n), 1'b0)]
                             : res_intt[wb_map(d_len, 3'(n), 1'b0)];
            nxt_b[n] = d_ntt ? res_ntt[wb_map(d_len, 3'(n), 1'b1)]
                             : res_intt[wb_map(d_len, 3'(n), 1'b1)];
        end
    end

    logic                  we_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic [CW-1:0]         da_q [8];
    logic [CW-1:0]         db_q [8];

    // Write port is zeroed whenever no write is issued.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            for (int n = 0; n < 8; n++) begin
                da_q[n] <= '0;
                db_q[n] <= '0;
            end
        end else begin
            we_q     <= wr_go;
            addr_a_q <= wr_go ? d_ra : '0;
            addr_b_q <= wr_go ? d_rb : '0;
            for (int n = 0; n < 8; n++) begin
                da_q[n] <= wr_go ? nxt_a[n] : '0;
                db_q[n] <= wr_go ? nxt_b[n] : '0;
            end
            if (d_valid && !d_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] cnt_q;
    logic             last_wr;

    // Counts beats visible on the write port; holds across input gaps.
    assign last_wr = we_q && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (we_q) begin
            cnt_q <= last_wr ? '0 : cnt_q + 1'b1;
        end
    end

    wb_state_t state_q;
    wb_state_t state_d;
    logic      inflight;

    assign inflight = in_valid_i | (|d_vld) | we_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (last_wr) begin
                    state_d = ST_DONE;
                end else if (inflight) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (last_wr) begin
                    state_d = ST_DONE;
                end else if (d_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_wr) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // a stage of one beat can finish again straight away
                if (last_wr) begin
                    state_d = ST_DONE;
                end else if (inflight) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en_o      = we_q;
    assign err_o        = err_q;
    assign wr_addr_a_o  = addr_a_q;
    assign wr_addr_b_o  = addr_b_q;
    assign stage_done_o = (state_q == ST_DONE);
    assign busy_o       = (|d_vld) | we_q | (state_q != ST_IDLE);

    assign wr_data_a0 = da_q[0];
    assign wr_data_a1 = da_q[1];
    assign wr_data_a2 = da_q[2];
    assign wr_data_a3 = da_q[3];
    assign wr_data_a4 = da_q[4];
    assign wr_data_a5 = da_q[5];
    assign wr_data_a6 = da_q[6];
    assign wr_data_a7 = da_q[7];
    assign wr_data_b0 = db_q[0];
    assign wr_data_b1 = db_q[1];
    assign wr_data_b2 = db_q[2];
    assign wr_data_b3 = db_q[3];
    assign wr_data_b4 = db_q[4];
    assign wr_data_b5 = db_q[5];
    assign wr_data_b6 = db_q[6];
    assign wr_data_b7 = db_q[7];

endmodule
